// File: rtl/lsu_axi_arbiter.sv
// Round-robin arbiter folding NUM_REQ LSU request ports onto one AXI4 master.
// Ports: clk/reset; per-LSU read/write valid, address, data and ready pulse;
// busy, sticky axi_error; full m_axi_aw/w/b/ar/r master channel set.
module lsu_axi_arbiter #(
  parameter int NUM_REQ    = 17,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQ-1:0]                   lsu_read_valid,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   lsu_read_address,
  output logic [NUM_REQ-1:0]                   lsu_read_ready,
  output logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   lsu_read_data,
  input  logic [NUM_REQ-1:0]                   lsu_write_valid,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   lsu_write_address,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   lsu_write_data,
  output logic [NUM_REQ-1:0]                   lsu_write_ready,
  output logic                                 busy,
  output logic                                 axi_error,
  output logic [ID_WIDTH-1:0]                  m_axi_awid,
  output logic [ADDR_WIDTH-1:0]                m_axi_awaddr,
  output logic [7:0]                           m_axi_awlen,
  output logic [2:0]                           m_axi_awsize,
  output logic [1:0]                           m_axi_awburst,
  output logic                                 m_axi_awvalid,
  input  logic                                 m_axi_awready,
  output logic [DATA_WIDTH-1:0]                m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]              m_axi_wstrb,
  output logic                                 m_axi_wlast,
  output logic                                 m_axi_wvalid,
  input  logic                                 m_axi_wready,
  input  logic [ID_WIDTH-1:0]                  m_axi_bid,
  input  logic [1:0]                           m_axi_bresp,
  input  logic                                 m_axi_bvalid,
  output logic                                 m_axi_bready,
  output logic [ID_WIDTH-1:0]                  m_axi_arid,
  output logic [ADDR_WIDTH-1:0]                m_axi_araddr,
  output logic [7:0]                           m_axi_arlen,
  output logic [2:0]                           m_axi_arsize,
  output logic [1:0]                           m_axi_arburst,
  output logic                                 m_axi_arvalid,
  input  logic                                 m_axi_arready,
  input  logic [ID_WIDTH-1:0]                  m_axi_rid,
  input  logic [DATA_WIDTH-1:0]                m_axi_rdata,
  input  logic [1:0]                           m_axi_rresp,
  input  logic                                 m_axi_rlast,
  input  logic                                 m_axi_rvalid,
  output logic                                 m_axi_rready
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W:0]   NREQ_W = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST   = IDX_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR,
    WR_RESP,
    RESP
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic                   is_wr_q, is_wr_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic                   aw_done_q, aw_done_d;
  logic                   w_done_q, w_done_d;
  logic                   err_q, err_d;
  logic                   rd_cap;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] rdata_q;

  logic                   pick_found;
  logic                   pick_wr;
  logic [IDX_W-1:0]       pick_idx;
  logic [IDX_W:0]         cand;
  logic [ADDR_WIDTH-1:0]  pick_addr;
  logic                   aw_hs;
  logic                   w_hs;

  // rid, bid and rlast carry no information for single-beat, single-ID use
  logic unused_axi_in;
  assign unused_axi_in = ^{m_axi_bid, m_axi_rid, m_axi_rlast};

  // First requester at or after rr_ptr (modulo NUM_REQ); read beats write
  always_comb begin
    pick_found = 1'b0;
    pick_wr    = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
      if (cand >= NREQ_W) begin
        cand = cand - NREQ_W;
      end
      if (!pick_found &&
          (lsu_read_valid[cand] || lsu_write_valid[cand])) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
        pick_wr    = !lsu_read_valid[cand];
      end
    end
  end

  assign pick_addr = pick_wr ? lsu_write_address[pick_idx]
                             : lsu_read_address[pick_idx];

  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs  = m_axi_wvalid && m_axi_wready;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    is_wr_d   = is_wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    err_d     = err_q;
    rd_cap    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d   = pick_idx;
          is_wr_d   = pick_wr;
          addr_d    = {pick_addr[ADDR_WIDTH-3:0], 2'b00};
          wdata_d   = lsu_write_data[pick_idx];
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = pick_wr ? WR_ADDR : RD_ADDR;
        end
      end
      RD_ADDR: begin
        if (m_axi_arready) begin
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (m_axi_rvalid) begin
          rd_cap = 1'b1;
          if (m_axi_rresp != 2'b00) begin
            err_d = 1'b1;
          end
          state_d = RESP;
        end
      end
      WR_ADDR: begin
        // AW and W complete independently, in either order
        if (aw_hs) begin
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00) begin
            err_d = 1'b1;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        rr_ptr_d = (grant_q == LAST) ? '0 : grant_q + 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      is_wr_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      is_wr_q   <= is_wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (rd_cap) begin
      rdata_q[grant_q] <= m_axi_rdata;
    end
  end

  assign lsu_read_data = rdata_q;

  assign lsu_read_ready  = (state_q == RESP && !is_wr_q)
                         ? (NUM_REQ'(1) << grant_q) : '0;
  assign lsu_write_ready = (state_q == RESP && is_wr_q)
                         ? (NUM_REQ'(1) << grant_q) : '0;

  assign busy      = (state_q != IDLE);
  assign axi_error = err_q;

  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = 3'b010;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = (state_q == WR_ADDR) && !aw_done_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = 1'b1;
  assign m_axi_wvalid  = (state_q == WR_ADDR) && !w_done_q;
  assign m_axi_bready  = (state_q == WR_RESP);
  assign m_axi_arid    = '0;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = 3'b010;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = (state_q == RD_ADDR);
  assign m_axi_rready  = (state_q == RD_DATA);

endmodule
